// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded RV32 field packets (R/I/S formats) into 32-bit instruction
//   words and writes them sequentially into instruction memory, starting at
//   BASE_ADDR after each start.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start               begin a load run (ignored while busy)
//   in_valid/in_ready   field packet handshake; in_last marks the final packet
//   fmt                 00=R, 01=I, 10=S, 11=illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm12   decoded fields
//   mem_we/mem_addr/mem_wdata   registered memory write port, one word/cycle
//   busy, done          run status
//   count               words written in this run
//   err                 sticky: bit0 format/opcode mismatch, bit1 address overflow
//
// Build option:
//   NOP_PAD_EN  when defined, the end of a program is followed by filling the
//               remaining addresses up to DEPTH-1 with addi x0,x0,0.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       imm12,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err
);

  // The pointer carries one extra bit so it can step past DEPTH-1 without
  // wrapping back onto address 0.
  localparam logic [ADDR_W:0]   BASE_PTR  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_PTR  = {1'b0, {ADDR_W{1'b1}}};
`ifdef NOP_PAD_EN
  localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
`endif

`ifdef NOP_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t          state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic            accept, legal, at_last, start_run;
  logic [31:0]     packed_word;

  assign accept    = in_valid && in_ready;
  assign at_last   = (ptr == LAST_PTR);
  assign start_run = start && (state == S_IDLE || state == S_DONE);

  // Field packing and opcode/format consistency check
  always_comb begin
    legal       = 1'b0;
    packed_word = '0;
    case (fmt)
      2'b00: begin
        legal       = (opcode[5:4] == 2'b11);
        packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      2'b01: begin
        legal       = !opcode[5];
        packed_word = {imm12, rs1, funct3, rd, opcode};
      end
      2'b10: begin
        legal       = (opcode[5:4] == 2'b10);
        packed_word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (in_last) begin
`ifdef NOP_PAD_EN
            // A final word that already landed on DEPTH-1 leaves nothing to pad
            state_nxt = (legal && at_last) ? S_DONE : S_PAD;
`else
            state_nxt = S_DONE;
`endif
          end else if (legal && at_last) begin
            state_nxt = S_DONE;
          end
        end
      end
`ifdef NOP_PAD_EN
      S_PAD: if (at_last) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    in_ready = (state == S_LOAD);
    done     = (state == S_DONE);
    busy     = (state == S_LOAD);
`ifdef NOP_PAD_EN
    busy     = (state == S_LOAD) || (state == S_PAD);
`endif
  end

  // Write port, pointer, count and error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= BASE_PTR;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_A;
      mem_wdata <= '0;
      count     <= '0;
      err       <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_run) begin
        ptr      <= BASE_PTR;
        mem_addr <= BASE_A;
        count    <= '0;
        err      <= '0;
      end else if (state == S_LOAD && accept) begin
        if (legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr[ADDR_W-1:0];
          mem_wdata <= packed_word;
          ptr       <= ptr + 1'b1;
          count     <= count + 1'b1;
          if (at_last && !in_last) err[1] <= 1'b1;
        end else begin
          err[0] <= 1'b1;
        end
      end
`ifdef NOP_PAD_EN
      else if (state == S_PAD) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr[ADDR_W-1:0];
        mem_wdata <= NOP_WORD;
        ptr       <= ptr + 1'b1;
        count     <= count + 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction field splitter: accepts decoded field packets (opcode, rs1, rs2, rd, funct3, funct7, imm12) and packs them into 32-bit RV32 R/I/S-type words.
- Writes packed words sequentially into instruction memory through a write port.
- Used at bring-up and in test benches to load programs from field-level descriptions.
- Valid/ready input side, one-stage registered write side, run-control FSM.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start; must be < DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a load run; ignored while busy.
- in_valid  in  1  field packet valid.
- in_ready  out  1  block can accept a packet this cycle.
- in_last  in  1  marks final packet of program.
- fmt  in  2  00=R, 01=I, 10=S, 11=illegal.
- opcode  in  7  instruction opcode.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- imm12  in  12  immediate (I and S).
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  packed instruction.
- busy  out  1  high in LOAD or PAD.
- done  out  1  high in DONE until next start.
- count  out  ADDR_W+1  words written in this run.
- err  out  2  sticky; bit0 = format/opcode mismatch, bit1 = address overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces: state IDLE; in_ready, mem_we, busy, done = 0; mem_addr = BASE_ADDR; mem_wdata, count, err = 0. Reset mid-run abandons the run with no further writes.
- States: IDLE, LOAD, (PAD), DONE.
  - IDLE/DONE + start: go to LOAD; clear count and err; pointer = BASE_ADDR; done falls.
  - start in LOAD/PAD: ignored.
- in_ready = (state==LOAD). A packet is accepted on a cycle with in_valid and in_ready.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm12, rs1, funct3, rd, opcode}
  - S: {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode}
- Consistency check on opcode bits, to match the field splitter:
  - R requires opcode[5:4]=11.
  - S requires opcode[5:4]=10.
  - I requires opcode[5]=0.
  - A mismatch, or fmt=11, sets err[0]. That packet is dropped: no write, pointer and count unchanged.
- Latency: a legal packet accepted at edge N produces mem_we=1 with mem_addr=pointer and mem_wdata=packed word during cycle N+1. Sustained one word per cycle. mem_we is 0 on any cycle without a legal accept in the previous cycle.
- Pointer and count each increment by 1 per write.
- Accepted packet with in_last (legal or dropped): next state DONE (or PAD with the option enabled); in_ready falls the next cycle.
- Overflow: a legal write to address DEPTH-1 without in_last:
  - sets err[1];
  - goes to DONE;
  - pointer does not wrap; no write to address 0.
- A write to DEPTH-1 with in_last is normal completion with no error.
- In DONE: in_ready=0, mem_we=0; count, err and mem_addr hold.

Optional Feature:
- Macro NOP_PAD_EN.
- Defined: in_last moves the FSM to PAD instead of DONE.
  - PAD writes 0x00000013 (addi x0,x0,0) to each remaining address through DEPTH-1, one per cycle, counting in count. Then DONE.
  - If the last program word landed at DEPTH-1, PAD is skipped.
  - in_ready=0 and busy=1 during PAD.
- Undefined: no PAD state; in_last goes directly to DONE.

Test Plan:
- Reset then start; send R add x3,x1,x2 (op 0110011, f3 000, f7 0) -> mem_we one cycle later, addr 0, wdata 0x002081B3, count 1.
- Back-to-back I addi x5,x0,10 (op 0010011, imm 10) then S sw x2,8(x1) (op 0100011, f3 010, in_last) -> wdata 0x00A00293 at addr 0, then 0x0020A423 at addr 1 on consecutive cycles; done=1, count=2, err=00.
- fmt=00 with opcode 0000011, then fmt=11 -> both dropped, no mem_we, err=01; the following legal packet is written at the unchanged address.
- ADDR_W=2: send 5 legal packets without in_last -> 4 writes to addrs 0..3, err=10, done=1, in_ready low after 4th accept; 5th never accepted.
- Assert rst_n=0 for one cycle mid-stream -> next cycle all outputs at reset values, no mem_we, start ignored until after reset releases.
- With NOP_PAD_EN and ADDR_W=3: 3 packets, last with in_last -> addrs 3..7 written with 0x00000013 on 5 consecutive cycles, count=8, then done=1.
